// File: rtl/morph_pkg.sv
// Shared encodings for the morphology window controller: datapath modes,
// window size and timing-lock FSM states.
package morph_pkg;

    localparam int unsigned WIN_SIZE = 5;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ERODE  = 2'd1,
        MODE_DILATE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

endpackage

// File: rtl/edge_det.sv
// Single-bit rise/fall detector; the history register clears on reset so a
// level already high at reset release yields one rise.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise_c,
    output logic fall_c
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise_c = sig & ~sig_q;
    assign fall_c = ~sig & sig_q;

endmodule

// File: rtl/morph_geom_ctrl.sv
// Video timing lock and frame-aligned mode sequencing for the 5x5 morphology
// window: measures the line period, drives the line-buffer length and mode.
module morph_geom_ctrl
    import morph_pkg::*;
#(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned LOCK_LINES = 4,
    parameter int unsigned WIN        = WIN_SIZE,
    parameter int unsigned MIN_LEN    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [1:0]       mode_req,
    input  logic             mode_req_valid,
    output logic [CNT_W-1:0] h_size,
    output logic             h_size_valid,
    output logic             locked,
    output logic [1:0]       mode_active,
    output logic [CNT_W-1:0] active_width,
    output logic [CNT_W-1:0] frame_lines,
    output logic             frame_done,
    output logic [7:0]       unlock_cnt
);

    localparam int unsigned      MATCH_W = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic hs_rise, vs_rise, de_fall;
    logic hs_fall_unused, vs_fall_unused, de_rise_unused;

    edge_det u_hs_edge (.clk(clk), .rst(rst), .sig(hsync), .rise_c(hs_rise),        .fall_c(hs_fall_unused));
    edge_det u_vs_edge (.clk(clk), .rst(rst), .sig(vsync), .rise_c(vs_rise),        .fall_c(vs_fall_unused));
    edge_det u_de_edge (.clk(clk), .rst(rst), .sig(de),    .rise_c(de_rise_unused), .fall_c(de_fall));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lcnt_q, lcnt_d;
    logic [CNT_W-1:0]   ref_q, ref_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               locked_q, locked_d;
    logic [CNT_W-1:0]   h_size_q, h_size_d;
    logic [7:0]         unlock_q, unlock_d;
    mode_e              pending_q, pending_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   aw_cnt_q, aw_cnt_d;
    logic [CNT_W-1:0]   active_width_q, active_width_d;
    logic [CNT_W-1:0]   fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0]   frame_lines_q, frame_lines_d;
    logic               frame_done_q, frame_done_d;

    logic               p_valid;
    logic               sat_evt;
    logic               lose_lock;
    logic [CNT_W-1:0]   aw_base;
    logic [CNT_W-1:0]   fl_plus;

    // Period is the line counter value seen at the hsync rise; saturation fires once.
    assign p_valid = (lcnt_q >= CNT_W'(MIN_LEN));
    assign sat_evt = ~hs_rise && (lcnt_q == CNT_MAX - CNT_W'(1));

    always_comb begin
        state_d        = state_q;
        ref_d          = ref_q;
        match_d        = match_q;
        lose_lock      = 1'b0;
        lcnt_d         = lcnt_q;
        unlock_d       = unlock_q;
        pending_d      = pending_q;
        mode_d         = mode_q;
        aw_cnt_d       = aw_cnt_q;
        active_width_d = active_width_q;
        fl_cnt_d       = fl_cnt_q;
        frame_lines_d  = frame_lines_q;
        frame_done_d   = vs_rise;
        aw_base        = '0;
        fl_plus        = '0;

        if (hs_rise) begin
            lcnt_d = CNT_W'(1);
        end else if (lcnt_q != CNT_MAX) begin
            lcnt_d = lcnt_q + CNT_W'(1);
        end

        if (sat_evt) begin
            state_d   = ST_SEARCH;
            match_d   = '0;
            lose_lock = (state_q == ST_LOCKED);
        end else if (hs_rise) begin
            case (state_q)
                ST_SEARCH: state_d = ST_MEASURE;
                ST_MEASURE: begin
                    if (p_valid) begin
                        ref_d   = lcnt_q;
                        match_d = MATCH_W'(1);
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (p_valid && (lcnt_q == ref_q)) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == MATCH_W'(LOCK_LINES)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_d   = lcnt_q;
                        match_d = MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (lcnt_q != ref_q) begin
                        ref_d     = lcnt_q;
                        match_d   = MATCH_W'(1);
                        state_d   = ST_VERIFY;
                        lose_lock = 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
        h_size_d = locked_d ? (ref_d - CNT_W'(WIN)) : '0;

        if (lose_lock && (unlock_q != 8'hFF)) begin
            unlock_d = unlock_q + 8'd1;
        end

        // A request coinciding with vsync rise is applied at that same frame boundary.
        if (mode_req_valid && (mode_req != 2'd3)) begin
            pending_d = mode_e'(mode_req);
        end
        if (!locked_q) begin
            mode_d = MODE_BYPASS;
        end else if (vs_rise) begin
            mode_d = pending_d;
        end

        aw_base = hs_rise ? '0 : aw_cnt_q;
        aw_cnt_d = (de && (aw_base != CNT_MAX)) ? aw_base + CNT_W'(1) : aw_base;
        if (de_fall) begin
            active_width_d = aw_cnt_q;
        end

        // A de fall on the vsync edge still belongs to the closing frame.
        fl_plus = fl_cnt_q + CNT_W'(de_fall);
        if (vs_rise) begin
            frame_lines_d = fl_plus;
            fl_cnt_d      = '0;
        end else begin
            fl_cnt_d      = fl_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SEARCH;
            lcnt_q         <= '0;
            ref_q          <= '0;
            match_q        <= '0;
            locked_q       <= 1'b0;
            h_size_q       <= '0;
            unlock_q       <= '0;
            pending_q      <= MODE_BYPASS;
            mode_q         <= MODE_BYPASS;
            aw_cnt_q       <= '0;
            active_width_q <= '0;
            fl_cnt_q       <= '0;
            frame_lines_q  <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lcnt_q         <= lcnt_d;
            ref_q          <= ref_d;
            match_q        <= match_d;
            locked_q       <= locked_d;
            h_size_q       <= h_size_d;
            unlock_q       <= unlock_d;
            pending_q      <= pending_d;
            mode_q         <= mode_d;
            aw_cnt_q       <= aw_cnt_d;
            active_width_q <= active_width_d;
            fl_cnt_q       <= fl_cnt_d;
            frame_lines_q  <= frame_lines_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign h_size       = h_size_q;
    assign h_size_valid = locked_q;
    assign locked       = locked_q;
    assign mode_active  = mode_q;
    assign active_width = active_width_q;
    assign frame_lines  = frame_lines_q;
    assign frame_done   = frame_done_q;
    assign unlock_cnt   = unlock_q;

endmodule
